// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter and sequencer for the external
// data/MMIO bus. Master 0 is the CPU data port and master 1 is the debug/DMA port.
// The arbiter handles one transaction at a time in three steps: IDLE -> BUSY -> DONE.
// All outputs come straight from flops.
//
// Optional feature: define BUS_TIMEOUT_EN to abort a BUSY phase after TIMEOUT cycles
// without s_ready. The abort acks the granted master with err=1, and an aborted read
// returns 32'hDEADBEEF. If the macro is undefined, err is tied low and BUSY waits
// indefinitely.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   mN_req/we/addr/wdata       master N request; held stable until mN_ack
//   mN_rdata, mN_ack           read data (held after ack), 1-cycle completion pulse
//   s_req/we/addr/wdata        slave strobe and latched transaction fields
//   s_rdata, s_ready           slave read data and completion
//   gnt                        one-hot current owner, 00 when idle
//   err                        timeout abort pulse, coincident with ack
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic [1:0]    gnt,
  output logic          err
);

  // A zero timeout would abort every transaction before the slave could respond.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          s_req_q, s_req_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;  // index of the master served most recently
  logic          pick_m1;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // On a tie, grant the master that was not served last.
  assign pick_m1 = m1_req && (!m0_req || !last_q);

  always_comb begin
    state_d    = state_q;
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    gnt_d      = gnt_q;
    last_d     = last_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          s_we_d    = pick_m1 ? m1_we    : m0_we;
          s_addr_d  = pick_m1 ? m1_addr  : m0_addr;
          s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          gnt_d     = pick_m1 ? 2'b10 : 2'b01;
          s_req_d   = 1'b1;
          state_d   = StBusy;
`ifdef BUS_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StBusy: begin
        // A slave response wins over a timeout that expires in the same cycle.
        if (s_ready) begin
          if (!s_we_q) begin
            if (gnt_q[1]) m1_rdata_d = s_rdata;
            else          m0_rdata_d = s_rdata;
          end
          s_req_d  = 1'b0;
          m0_ack_d = gnt_q[0];
          m1_ack_d = gnt_q[1];
          last_d   = gnt_q[1];
          state_d  = StDone;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          if (!s_we_q) begin
            if (gnt_q[1]) m1_rdata_d = DW'(32'hDEADBEEF);
            else          m0_rdata_d = DW'(32'hDEADBEEF);
          end
          s_req_d  = 1'b0;
          m0_ack_d = gnt_q[0];
          m1_ack_d = gnt_q[1];
          last_d   = gnt_q[1];
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        s_req_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      s_req_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_req_q    <= s_req_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign gnt      = gnt_q;
`ifdef BUS_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the single-cycle CPU's external data/MMIO bus.
- Master 0 is the CPU data port; master 1 is the debug/DMA port.
- Grants one transaction at a time, round-robin.
- Latches the request, drives the slave strobe, waits for slave ready, and returns read data with a one-cycle ack to the granted master.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max BUSY cycles before abort (used only with BUS_TIMEOUT_EN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- m0_req  input  1  CPU request, held until m0_ack
- m0_we  input  1  CPU write enable
- m0_addr  input  AW  CPU address
- m0_wdata  input  DW  CPU write data
- m0_rdata  output  DW  CPU read data, valid with m0_ack, held afterwards
- m0_ack  output  1  CPU completion pulse, 1 cycle
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as m0, for debug/DMA master
- s_req  output  1  slave strobe, high throughout BUSY
- s_we  output  1  latched write enable
- s_addr  output  AW  latched address
- s_wdata  output  DW  latched write data
- s_rdata  input  DW  slave read data, sampled when s_ready=1
- s_ready  input  1  slave completion
- gnt  output  2  one-hot current owner (00 when IDLE)
- err  output  1  timeout abort pulse, coincident with ack

Behaviour:
- All outputs are registered.
- Reset (async, any state including mid-transaction):
  - state=IDLE; s_req=0, s_we=0, s_addr=0, s_wdata=0
  - m0_rdata=m1_rdata=0, acks=0, gnt=00, err=0
  - last-served pointer=1, so m0 wins the first tie
  - Slave transaction is abandoned; no ack is issued.
- States:
  - IDLE: if neither req, stay. If exactly one req, grant it. If both, grant the master not served last. On grant: latch we/addr/wdata from that master, set gnt, s_req=1, go BUSY.
  - BUSY: s_req held at 1, latched fields stable. When s_ready=1:
    - read: capture s_rdata into the granted master's rdata
    - write: that rdata is unchanged
    - then drop s_req, assert the granted ack, update the pointer, go DONE
  - DONE: ack high for exactly this cycle; gnt still valid. Next state IDLE; gnt cleared.
- Latency:
  - req seen high at edge N
  - s_req high in cycle N+1
  - with s_ready=1 in N+1: ack high in cycle N+2, then IDLE in N+3
  - each extra wait cycle adds 1
- Handshake:
  - A master keeps req and its fields stable until it sees ack=1; it may drop or re-assert req at the edge ending the ack cycle.
  - Requests arriving during BUSY/DONE wait; they are sampled only in IDLE.
  - No back-to-back grants without IDLE, so throughput is 1 transaction per 3 cycles minimum.
- Fairness: with both requesting continuously, grants strictly alternate m0, m1, m0, …
- The non-granted master's req and fields are ignored and never affect s_* outputs.
- s_ready outside BUSY is ignored.
- The ack of the non-granted master is always 0; m0_ack and m1_ack are never high together.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT, abort: s_req=0, go DONE, ack granted master, err=1 for the DONE cycle.
  - Aborted reads load that master's rdata with 32'hDEADBEEF.
  - Pointer updates as normal.
  - s_ready in the same cycle the counter hits TIMEOUT wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely; err tied 0.

Test Plan:
- m0 read addr 0x08, slave returns 0x0000_0001 with s_ready in first BUSY cycle -> s_addr=0x08, s_we=0; m0_ack 2 cycles after req sampled; m0_rdata=1; m1_ack stays 0.
- m1 write addr 0x10 data 0xA5A5A5A5, s_ready after 3 wait cycles -> s_req high 4 cycles, s_wdata stable; m1_ack once; m1_rdata unchanged.
- Both req asserted together from reset, held continuously for 4 transactions -> gnt order 01,10,01,10 (m0 first); acks alternate.
- m0_addr changes while m1 is granted -> s_addr keeps m1's latched address until DONE.
- rst asserted mid-BUSY -> s_req, gnt, acks drop immediately; after release, a both-req tie grants m0.
- With BUS_TIMEOUT_EN, TIMEOUT=16, m0 read, s_ready never asserted -> ack plus err exactly 16 BUSY cycles after entry; m0_rdata=0xDEADBEEF. Without the macro: no ack after 100 cycles.
